// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants.
package pipeline_pkg;

    localparam int PC_W = 32;
    localparam int IR_W = 32;

    localparam logic [IR_W-1:0] NOP_IR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, ir} prefetch buffer. Entry 0 is always the head, so the
// head outputs come straight from registers with no read mux.
import pipeline_pkg::*;

module fetch_fifo (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [PC_W-1:0] push_pc,
    input  logic [IR_W-1:0] push_ir,
    output logic [1:0]      count,
    output logic [PC_W-1:0] head_pc,
    output logic [IR_W-1:0] head_ir
);

    logic [PC_W-1:0] pc0, pc1;
    logic [IR_W-1:0] ir0, ir1;

    // Occupancy and shift-register storage; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        pc0   <= push_pc;
                        ir0   <= push_ir;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        pc0 <= push_pc;
                        ir0 <= push_ir;
                    end else if (push) begin
                        pc1   <= push_pc;
                        ir1   <= push_ir;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // A full buffer never accepts a push.
                    if (pop) begin
                        pc0   <= pc1;
                        ir0   <= ir1;
                        count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    assign head_pc = pc0;
    assign head_ir = ir0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: request FSM, fetch PC and a 2-entry prefetch buffer
// feeding the ID stage.
//
//  state | meaning
//  IDLE  | no request outstanding
//  REQ   | request outstanding, returned data is kept
//  DROP  | request outstanding, returned data is discarded (redirected)
import pipeline_pkg::*;

module instr_fetch #(
    parameter logic [IR_W-1:0] NOP_IR     = pipeline_pkg::NOP_IR,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IR_W-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    output logic [IR_W-1:0] ir,
    output logic [PC_W-1:0] ir_pc,
    output logic            ir_valid
);

    localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [PC_W-1:0] req_addr, req_addr_nxt;
    logic            push, pop;
    logic [1:0]      count;
    logic [2:0]      count_after;
    logic [PC_W-1:0] head_pc;
    logic [IR_W-1:0] head_ir;

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .push_pc (fetch_pc),
        .push_ir (imem_rdata),
        .count   (count),
        .head_pc (head_pc),
        .head_ir (head_ir)
    );

    assign ir_valid    = (count != 2'd0);
    assign ir          = ir_valid ? head_ir : NOP_IR;
    assign ir_pc       = ir_valid ? head_pc : '0;
    assign pop         = ir_valid && !stall && !redirect;
    assign count_after = {1'b0, count} + 3'd1 - {2'b00, pop};

    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = req_addr;

    // Next state, next fetch PC and request address; redirect retargets last.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && ({1'b0, count} < DEPTH_L)) begin
                    state_nxt    = REQ;
                    req_addr_nxt = fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_nxt = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + 1'b1;
                    if (count_after < DEPTH_L) begin
                        state_nxt    = REQ;
                        req_addr_nxt = fetch_pc + 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_nxt = redirect_pc;
        end
    end

    // State, PC and held request address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= '0;
            req_addr <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: NOP_IR, default 32'h0000_0000, instruction word emitted whenever no valid instruction is presented.
REQ-002 Parameter: FIFO_DEPTH, default 2, number of prefetch buffer entries; only 2 is supported.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 imem_req  out  1  instruction memory request.
REQ-006 imem_addr  out  32  word address of the request.
REQ-007 imem_ack  in  1  transfer completes in any cycle where imem_req && imem_ack.
REQ-008 imem_rdata  in  32  instruction word, valid in the ack cycle.
REQ-009 redirect  in  1  taken branch/jump from the EX stage (BrA/RAA select).
REQ-010 redirect_pc  in  32  target word address.
REQ-011 stall  in  1  ID stage cannot accept an instruction this cycle.
REQ-012 ir  out  32  instruction presented to ID.
REQ-013 ir_pc  out  32  word address of ir.
REQ-014 ir_valid  out  1  ir/ir_pc hold a real fetched instruction.

Function
REQ-015 fetch_pc increments by 1 (word addressing) on each accepted request; 32'hFFFF_FFFF wraps to 0.
REQ-016 The FSM has exactly three states: IDLE (no request), REQ (request outstanding, data kept), DROP (request outstanding, data discarded).
REQ-017 imem_req is 1 exactly in REQ and DROP; imem_addr is stable from assertion until the ack cycle.
REQ-018 IDLE->REQ when fifo_count < FIFO_DEPTH and no redirect; imem_addr = fetch_pc.
REQ-019 REQ with ack and no redirect: push {fetch_pc, imem_rdata}, fetch_pc+1; next state REQ if space remains after push/pop, else IDLE.
REQ-020 REQ with redirect and no ack -> DROP; REQ with redirect and ack -> IDLE, data discarded.
REQ-021 DROP with ack -> IDLE; data is never pushed.
REQ-022 On redirect: FIFO flushed, fetch_pc = redirect_pc, ir_valid = 0 from the next cycle; redirect overrides stall and any push.
REQ-023 Redirect during DROP retargets fetch_pc only; the state stays DROP.
REQ-024 ir/ir_pc/ir_valid are driven from the FIFO head; when the FIFO is empty: ir = NOP_IR, ir_pc = 0, ir_valid = 0.
REQ-025 The head pops at the clock edge when ir_valid && !stall && !redirect.
REQ-026 Simultaneous push and pop at count 1 leaves count 1; no push occurs at count 2, and no overflow or underflow is possible.
REQ-027 Latency: request issued in cycle N with ack in cycle N gives ir_valid in cycle N+1; sustained throughput is 1 instruction/cycle with zero-wait memory and no stall.

Reset
REQ-028 While rst is high, all of the following hold: state IDLE, fetch_pc = 0, FIFO empty, imem_req = 0, imem_addr = 0, ir = NOP_IR, ir_pc = 0, ir_valid = 0.
REQ-029 Reset asserted mid-transaction abandons it; an ack arriving while rst is high, or in IDLE, is ignored.
REQ-030 The first request (addr 0) is asserted in the cycle after the first edge with rst low.

Structure
REQ-031 Package pipeline_pkg holds NOP_IR, PC_W = 32, IR_W = 32, and the fetch state enum {IDLE, REQ, DROP}.
REQ-032 Sub-module fetch_fifo: 2-entry {pc, ir} FIFO with push, pop, flush, count, and head outputs; instr_fetch contains the FSM and PC logic.

Verification
REQ-033 Zero-wait memory (ack always 1), no stall -> ir_pc = 0,1,2,3 on consecutive cycles starting 1 cycle after the first request.
REQ-034 stall held high 5 cycles with ack=1 -> FIFO fills at 2, imem_req drops, ir_pc stays constant; release -> sequence continues with no gap or duplicate.
REQ-035 Ack delayed 3 cycles, redirect to 32'h40 in cycle 1 -> state DROP, late data not presented, next request addr 32'h40, first valid ir_pc = 32'h40.
REQ-036 redirect and ack in the same cycle (redirect_pc = 32'h100) -> rdata discarded, ir_valid = 0 next cycle, next imem_addr = 32'h100.
REQ-037 Redirect to 32'hFFFF_FFFF -> ir_pc sequence FFFF_FFFF, 0000_0000, 0000_0001.
REQ-038 rst pulsed while REQ outstanding -> all outputs at reset values, ack during reset ignored, refetch starts at addr 0.
